// File: rtl/cnn1d_pkg.sv
// Shared constants for the 1-D CNN datapath.
package cnn1d_pkg;
  parameter int unsigned DATA_WIDTH = 16;
endpackage

// File: rtl/dense_layer_ctrl.sv
// Sequencer that walks one shared neuron across all outputs of a dense layer.
// Optional ReLU on collected results: define DENSE_LAYER_CTRL_RELU_EN.
module dense_layer_ctrl
  import cnn1d_pkg::*;
#(
  parameter int unsigned NUM_INPUTS  = 4,
  parameter int unsigned NUM_NEURONS = 4,
  parameter int unsigned ADDR_WIDTH  = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1
) (
  input  logic                                   clk,
  input  logic                                   rst,
  output logic                                   layer_ready_in,
  input  logic                                   layer_valid_in,
  input  logic [NUM_INPUTS-1:0][DATA_WIDTH-1:0]  layer_data_in,
  output logic                                   wt_rd_en,
  output logic [ADDR_WIDTH-1:0]                  wt_rd_addr,
  input  logic [NUM_INPUTS-1:0][DATA_WIDTH-1:0]  wt_rd_weights,
  input  logic [DATA_WIDTH-1:0]                  wt_rd_bias,
  input  logic                                   nrn_ready_in,
  output logic                                   nrn_valid_in,
  output logic [NUM_INPUTS-1:0][DATA_WIDTH-1:0]  nrn_data_in,
  output logic [NUM_INPUTS-1:0][DATA_WIDTH-1:0]  nrn_weights,
  output logic [DATA_WIDTH-1:0]                  nrn_bias,
  input  logic                                   nrn_valid_out,
  input  logic [DATA_WIDTH-1:0]                  nrn_data_out,
  output logic                                   nrn_ready_out,
  input  logic                                   layer_ready_out,
  output logic                                   layer_valid_out,
  output logic [NUM_NEURONS-1:0][DATA_WIDTH-1:0] layer_data_out
);

  localparam int unsigned CntWidth = $clog2(NUM_NEURONS + 1);
  localparam logic [ADDR_WIDTH-1:0] LastIdx = ADDR_WIDTH'(NUM_NEURONS - 1);
  localparam logic [CntWidth-1:0] AllDone = CntWidth'(NUM_NEURONS);

  typedef enum logic [2:0] {StIdle, StFetch, StLoad, StIssue, StDrain, StOut} state_e;

  state_e state_q, state_d;
  logic [ADDR_WIDTH-1:0] issue_cnt_q, issue_cnt_d;
  logic [CntWidth-1:0] collect_cnt_q, collect_cnt_d;
  logic [NUM_INPUTS-1:0][DATA_WIDTH-1:0] in_buf_q, in_buf_d;
  logic [NUM_INPUTS-1:0][DATA_WIDTH-1:0] wt_buf_q, wt_buf_d;
  logic [DATA_WIDTH-1:0] bias_buf_q, bias_buf_d;
  logic [NUM_NEURONS-1:0][DATA_WIDTH-1:0] out_buf_q, out_buf_d;

  logic accept, issue_hs, collect;
  logic [DATA_WIDTH-1:0] result_stored;
  logic [ADDR_WIDTH-1:0] collect_idx;

  assign accept      = layer_valid_in & layer_ready_in;
  assign issue_hs    = nrn_valid_in & nrn_ready_in;
  assign collect     = nrn_valid_out & nrn_ready_out;
  assign collect_idx = collect_cnt_q[ADDR_WIDTH-1:0];

`ifdef DENSE_LAYER_CTRL_RELU_EN
  assign result_stored = nrn_data_out[DATA_WIDTH-1] ? '0 : nrn_data_out;
`else
  assign result_stored = nrn_data_out;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      issue_cnt_q   <= '0;
      collect_cnt_q <= '0;
      in_buf_q      <= '0;
      wt_buf_q      <= '0;
      bias_buf_q    <= '0;
      out_buf_q     <= '0;
    end else begin
      state_q       <= state_d;
      issue_cnt_q   <= issue_cnt_d;
      collect_cnt_q <= collect_cnt_d;
      in_buf_q      <= in_buf_d;
      wt_buf_q      <= wt_buf_d;
      bias_buf_q    <= bias_buf_d;
      out_buf_q     <= out_buf_d;
    end
  end

  // Results come back strictly in issue order, so a running count is the slot index.
  always_comb begin
    issue_cnt_d   = issue_cnt_q;
    collect_cnt_d = collect_cnt_q;
    in_buf_d      = in_buf_q;
    wt_buf_d      = wt_buf_q;
    bias_buf_d    = bias_buf_q;
    out_buf_d     = out_buf_q;
    if (accept) begin
      in_buf_d      = layer_data_in;
      issue_cnt_d   = '0;
      collect_cnt_d = '0;
    end
    if (state_q == StLoad) begin
      wt_buf_d   = wt_rd_weights;
      bias_buf_d = wt_rd_bias;
    end
    if (issue_hs) issue_cnt_d = issue_cnt_q + 1'b1;
    if (collect) begin
      out_buf_d[collect_idx] = result_stored;
      collect_cnt_d          = collect_cnt_q + 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (accept) state_d = StFetch;
      StFetch: state_d = StLoad;
      StLoad:  state_d = StIssue;
      StIssue: if (issue_hs) state_d = (issue_cnt_q < LastIdx) ? StFetch : StDrain;
      StDrain: if (collect_cnt_d == AllDone) state_d = StOut;
      StOut:   if (layer_ready_out) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    layer_ready_in  = 1'b0;
    wt_rd_en        = 1'b0;
    nrn_valid_in    = 1'b0;
    nrn_ready_out   = 1'b0;
    layer_valid_out = 1'b0;
    case (state_q)
      StIdle:  layer_ready_in = ~rst;
      StFetch: begin
        wt_rd_en      = 1'b1;
        nrn_ready_out = 1'b1;
      end
      StLoad:  nrn_ready_out = 1'b1;
      StIssue: begin
        nrn_valid_in  = 1'b1;
        nrn_ready_out = 1'b1;
      end
      StDrain: nrn_ready_out = 1'b1;
      StOut:   layer_valid_out = 1'b1;
      default: ;
    endcase
  end

  assign wt_rd_addr     = issue_cnt_q;
  assign nrn_data_in    = in_buf_q;
  assign nrn_weights    = wt_buf_q;
  assign nrn_bias       = bias_buf_q;
  assign layer_data_out = out_buf_q;

endmodule

// File: tb/tb_dense_layer_ctrl.sv
// Directed bench for dense_layer_ctrl with a 4-cycle neuron model that returns its bias.
module tb_dense_layer_ctrl;
  import cnn1d_pkg::*;

  localparam int DW  = DATA_WIDTH;
  localparam int LAT = 4;
  localparam int N   = 4;

  typedef logic [3:0][DW-1:0] vec_t;

  typedef struct {
    vec_t vin;
    vec_t bias;
    int   stall_idx;
    int   stall_len;
    int   hold;
    bit   keep_valid;
    vec_t keep_data;
    int   abort_idx;
    bit   drain_pulse;
    vec_t exp;
  } row_t;

  logic clk, rst;
  logic layer_ready_in, layer_valid_in;
  vec_t layer_data_in;
  logic wt_rd_en;
  logic [1:0] wt_rd_addr;
  vec_t wt_rd_weights;
  logic [DW-1:0] wt_rd_bias;
  logic nrn_ready_in, nrn_valid_in;
  vec_t nrn_data_in, nrn_weights;
  logic [DW-1:0] nrn_bias;
  logic nrn_valid_out;
  logic [DW-1:0] nrn_data_out;
  logic nrn_ready_out, layer_ready_out, layer_valid_out;
  vec_t layer_data_out;

  int n_vec = 0;
  int n_err = 0;

  vec_t wmem [4];
  vec_t bmem;

  dense_layer_ctrl #(.NUM_INPUTS(4), .NUM_NEURONS(N)) dut (
    .clk            (clk),
    .rst            (rst),
    .layer_ready_in (layer_ready_in),
    .layer_valid_in (layer_valid_in),
    .layer_data_in  (layer_data_in),
    .wt_rd_en       (wt_rd_en),
    .wt_rd_addr     (wt_rd_addr),
    .wt_rd_weights  (wt_rd_weights),
    .wt_rd_bias     (wt_rd_bias),
    .nrn_ready_in   (nrn_ready_in),
    .nrn_valid_in   (nrn_valid_in),
    .nrn_data_in    (nrn_data_in),
    .nrn_weights    (nrn_weights),
    .nrn_bias       (nrn_bias),
    .nrn_valid_out  (nrn_valid_out),
    .nrn_data_out   (nrn_data_out),
    .nrn_ready_out  (nrn_ready_out),
    .layer_ready_out(layer_ready_out),
    .layer_valid_out(layer_valid_out),
    .layer_data_out (layer_data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Weight memory: one cycle read latency.
  always @(posedge clk) begin
    if (wt_rd_en) begin
      wt_rd_weights <= wmem[wt_rd_addr];
      wt_rd_bias    <= bmem[wt_rd_addr];
    end
  end

  // Neuron model: fixed 4-stage pipeline returning the bias, cleared by the shared reset.
  logic [LAT-1:0] pv;
  logic [LAT-1:0][DW-1:0] pd;
  always @(posedge clk) begin
    if (rst) begin
      pv <= '0;
      pd <= '0;
    end else begin
      pv <= {pv[LAT-2:0], nrn_valid_in & nrn_ready_in};
      pd <= {pd[LAT-2:0], nrn_bias};
    end
  end
  assign nrn_valid_out = pv[LAT-1];
  assign nrn_data_out  = pd[LAT-1];

  function automatic vec_t mk(logic [DW-1:0] a, logic [DW-1:0] b, logic [DW-1:0] c,
                              logic [DW-1:0] d);
    vec_t v;
    v[0] = a;
    v[1] = b;
    v[2] = c;
    v[3] = d;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ready_in"}, 64'(layer_ready_in), 64'd0);
    chk({tag, "_nrn_valid_in"}, 64'(nrn_valid_in), 64'd0);
    chk({tag, "_wt_rd_en"}, 64'(wt_rd_en), 64'd0);
    chk({tag, "_wt_rd_addr"}, 64'(wt_rd_addr), 64'd0);
    chk({tag, "_valid_out"}, 64'(layer_valid_out), 64'd0);
    chk({tag, "_nrn_ready_out"}, 64'(nrn_ready_out), 64'd0);
    chk({tag, "_nrn_data_in"}, nrn_data_in, 64'd0);
    chk({tag, "_nrn_weights"}, nrn_weights, 64'd0);
    chk({tag, "_nrn_bias"}, 64'(nrn_bias), 64'd0);
    chk({tag, "_data_out"}, layer_data_out, 64'd0);
  endtask

  task automatic run_row(input row_t r);
    int   w, issue_idx, stall_rem, hold_rem, n_addr, lat, pulsed;
    bit   done;
    vec_t held_w, held_out;
    logic [DW-1:0] held_b;
    logic [1:0] addr_log [4];

    bmem = r.bias;
    layer_valid_in = 1'b1;
    layer_data_in  = r.vin;
    w = 0;
    while (!layer_ready_in && w < 200) begin
      tick();
      w++;
    end
    if (w >= 200) begin
      chk("accept_wait", 64'(layer_ready_in), 64'd1);
      return;
    end
    tick();
    if (r.keep_valid) layer_data_in = r.keep_data;
    else layer_valid_in = 1'b0;

    issue_idx = 0; stall_rem = r.stall_len; hold_rem = r.hold;
    n_addr = 0; lat = -1; pulsed = 0; done = 1'b0;
    held_w = '0; held_b = '0; held_out = '0;
    for (int k = 0; k < 300 && !done; k++) begin
      if (nrn_valid_out && !nrn_ready_out) chk("result_outside_window", 64'd1, 64'(nrn_ready_out));
      if (wt_rd_en) begin
        if (n_addr < 4) addr_log[n_addr] = wt_rd_addr;
        n_addr++;
      end
      if (layer_valid_out && lat < 0) lat = k + 1;

      if (nrn_valid_in && issue_idx == r.abort_idx) begin
        rst = 1'b1;
        tick();
        chk_reset_outputs("abort");
        rst = 1'b0;
        #1;
        chk("abort_ready_after", 64'(layer_ready_in), 64'd1);
        return;
      end

      if (nrn_valid_in) begin
        if (issue_idx == r.stall_idx && stall_rem > 0) begin
          if (stall_rem == r.stall_len) begin
            held_w = nrn_weights;
            held_b = nrn_bias;
          end else begin
            chk("stall_weights", nrn_weights, held_w);
            chk("stall_bias", 64'(nrn_bias), 64'(held_b));
          end
          nrn_ready_in = 1'b0;
          stall_rem--;
        end else begin
          chk("issue_weights", nrn_weights, wmem[issue_idx]);
          chk("issue_bias", 64'(nrn_bias), 64'(bmem[issue_idx]));
          chk("issue_data", nrn_data_in, r.vin);
          nrn_ready_in = 1'b1;
          issue_idx++;
        end
      end else begin
        nrn_ready_in = 1'b1;
      end

      if (pulsed == 1) begin
        layer_valid_in = 1'b0;
        chk("drain_pulse_buf", nrn_data_in, r.vin);
        pulsed = 2;
      end else if (r.drain_pulse && pulsed == 0 && issue_idx == N && !nrn_valid_in &&
                   !layer_valid_out) begin
        layer_valid_in = 1'b1;
        layer_data_in  = mk(16'h7777, 16'h7777, 16'h7777, 16'h7777);
        chk("drain_ready_in", 64'(layer_ready_in), 64'd0);
        pulsed = 1;
      end

      if (layer_valid_out) begin
        chk("out_ready_in", 64'(layer_ready_in), 64'd0);
        if (hold_rem > 0) begin
          if (hold_rem < r.hold) chk("out_hold_stable", layer_data_out, held_out);
          else held_out = layer_data_out;
          layer_ready_out = 1'b0;
          hold_rem--;
        end else begin
          if (r.hold > 0) chk("out_hold_final", layer_data_out, held_out);
          chk("layer_data_out", layer_data_out, r.exp);
          layer_ready_out = 1'b1;
          done = 1'b1;
        end
      end else begin
        layer_ready_out = 1'b0;
      end
      tick();
    end
    layer_ready_out = 1'b0;
    if (!done) begin
      chk("out_timeout", 64'(layer_valid_out), 64'd1);
      return;
    end
    chk("valid_dropped", 64'(layer_valid_out), 64'd0);
    chk("idle_after_out", 64'(layer_ready_in), 64'd1);
    chk("latency", 64'(lat), 64'(3 * N + LAT + 1 + r.stall_len));
    chk("fetch_count", 64'(n_addr), 64'(N));
    for (int i = 0; i < 4; i++) chk("fetch_addr", 64'(addr_log[i]), 64'(i));
  endtask

  row_t rows [8];
  vec_t b1234, v1234;

  initial begin
    for (int k = 0; k < 4; k++)
      for (int i = 0; i < 4; i++) wmem[k][i] = DW'(16 * k + i + 1);
    b1234 = mk(1, 2, 3, 4);
    v1234 = mk(1, 2, 3, 4);
    for (int i = 0; i < 8; i++) begin
      rows[i] = '{vin: v1234, bias: b1234, stall_idx: -1, stall_len: 0, hold: 0,
                  keep_valid: 1'b0, keep_data: '0, abort_idx: -1, drain_pulse: 1'b0,
                  exp: mk(1, 2, 3, 4)};
    end
    rows[1].stall_idx = 1;
    rows[1].stall_len = 5;
    rows[2].hold       = 3;
    rows[2].keep_valid = 1'b1;
    rows[2].keep_data  = mk(9, 8, 7, 6);
    rows[3].vin        = mk(9, 8, 7, 6);
    rows[4].abort_idx  = 2;
    rows[6].drain_pulse = 1'b1;
    rows[7].bias = mk(16'd5, 16'hFFFD, 16'd0, 16'hFFFF);
`ifdef DENSE_LAYER_CTRL_RELU_EN
    rows[7].exp = mk(16'd5, 16'd0, 16'd0, 16'd0);
`else
    rows[7].exp = mk(16'd5, 16'hFFFD, 16'd0, 16'hFFFF);
`endif

    bmem = b1234;
    rst = 1'b1;
    layer_valid_in = 1'b0;
    layer_data_in = '0;
    nrn_ready_in = 1'b1;
    layer_ready_out = 1'b0;
    repeat (3) tick();
    chk_reset_outputs("reset");
    rst = 1'b0;
    #1;
    chk("reset_release_ready", 64'(layer_ready_in), 64'd1);

    for (int i = 0; i < 8; i++) run_row(rows[i]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
